// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver fed by an active-low ring counter.
// It adds blanking between digits, double-buffers the displayed value per frame and flags illegal selects.
module seg7_scan_driver #(
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  digit_sel,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        lz_suppress,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        sel_err
);

  typedef enum logic [1:0] {BLANK, SHOW, ERR} state_t;

  localparam logic [3:0] CNT_INIT   = 4'(BLANK_CYCLES);
  localparam logic [3:0] CNT_RELOAD = 4'(BLANK_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] pend_val_q, act_val_q, act_val_d;
  logic [3:0]  pend_dp_q, act_dp_q, act_dp_d;
  logic [3:0]  an_d;
  logic [6:0]  seg_d;
  logic        dp_n_d, sel_err_d;
  logic        legal, changed, frame_start;
  logic [1:0]  idx;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Digit k is blanked under lz when its nibble and every higher nibble are zero; digit 0 always shows.
  function automatic logic [6:0] digit_seg(input logic [15:0] v, input logic [1:0] k, input logic lz);
    logic [3:0] nib;
    logic       zero_hi;
    case (k)
      2'd0: begin nib = v[3:0];   zero_hi = 1'b0; end
      2'd1: begin nib = v[7:4];   zero_hi = (v[15:4] == 12'h000); end
      2'd2: begin nib = v[11:8];  zero_hi = (v[15:8] == 8'h00); end
      default: begin nib = v[15:12]; zero_hi = (v[15:12] == 4'h0); end
    endcase
    return (lz && zero_hi) ? 7'b1111111 : hex_seg(nib);
  endfunction

  function automatic logic [1:0] sel_to_idx(input logic [3:0] s);
    case (s)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  assign legal       = ($countones(~digit_sel) == 1);
  assign changed     = legal && (digit_sel != sel_q);
  assign frame_start = changed && (digit_sel == 4'b1110);
  assign idx         = sel_to_idx(sel_q);

  always_comb begin
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    if (frame_start) begin
      act_val_d = load ? value : pend_val_q;
      act_dp_d  = load ? dp    : pend_dp_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    sel_err_d = sel_err;
    an_d      = 4'b1111;
    seg_d     = 7'b1111111;
    dp_n_d    = 1'b1;
    if (!legal) begin
      state_d   = ERR;
      sel_err_d = 1'b1;
      sel_d     = 4'b1111;
    end else if (changed) begin
      state_d = BLANK;
      sel_d   = digit_sel;
      cnt_d   = CNT_RELOAD;
    end else begin
      case (state_q)
        BLANK: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = SHOW;
            an_d    = sel_q;
            seg_d   = digit_seg(act_val_q, idx, lz_suppress);
            dp_n_d  = ~act_dp_q[idx];
          end
        end
        SHOW: begin
          an_d   = sel_q;
          seg_d  = digit_seg(act_val_q, idx, lz_suppress);
          dp_n_d = ~act_dp_q[idx];
        end
        default: state_d = ERR;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= BLANK;
      cnt_q      <= CNT_INIT;
      sel_q      <= 4'b1111;
      pend_val_q <= 16'h0000;
      pend_dp_q  <= 4'h0;
      act_val_q  <= 16'h0000;
      act_dp_q   <= 4'h0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp_n       <= 1'b1;
      sel_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      an        <= an_d;
      seg       <= seg_d;
      dp_n      <= dp_n_d;
      sel_err   <= sel_err_d;
      if (load) begin
        pend_val_q <= value;
        pend_dp_q  <= dp;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: reset, blank timing, frame buffering, lz, dp and illegal selects.
module tb_seg7_scan_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  digit_sel;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        lz_suppress;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        sel_err;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] S_OFF = 7'b1111111;
  localparam logic [6:0] S_0   = 7'b1000000;
  localparam logic [6:0] S_1   = 7'b1111001;
  localparam logic [6:0] S_4   = 7'b0011001;
  localparam logic [6:0] S_5   = 7'b0010010;
  localparam logic [6:0] S_A   = 7'b0001000;
  localparam logic [6:0] S_C   = 7'b1000110;
  localparam logic [6:0] S_E   = 7'b0000110;
  localparam logic [6:0] S_F   = 7'b0001110;

  seg7_scan_driver #(.BLANK_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .digit_sel(digit_sel), .load(load), .value(value),
    .dp(dp), .lz_suppress(lz_suppress), .an(an), .seg(seg), .dp_n(dp_n), .sel_err(sel_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // New select: two blank cycles (anodes and dp off), then the digit on the third edge.
  task automatic sel_show(input logic [3:0] s, input string tag);
    digit_sel = s;
    tick();
    load = 1'b0;
    chk({tag, "_blank1_an"}, 16'(an), 16'hF);
    chk({tag, "_blank1_dp"}, 16'(dp_n), 16'h1);
    tick();
    chk({tag, "_blank2_an"}, 16'(an), 16'hF);
    chk({tag, "_blank2_seg"}, 16'(seg), 16'(S_OFF));
    tick();
    chk({tag, "_show_an"}, 16'(an), 16'(s));
  endtask

  initial begin
    reset = 1'b0; digit_sel = 4'b1110; load = 1'b0; value = 16'h0; dp = 4'h0; lz_suppress = 1'b0;
    tick(); tick();
    chk("por_an", 16'(an), 16'hF);
    chk("por_seg", 16'(seg), 16'(S_OFF));
    chk("por_dpn", 16'(dp_n), 16'h1);
    chk("por_err", 16'(sel_err), 16'h0);

    // Load 1234 while digit3 is selected; it stays pending until the next frame start.
    reset = 1'b1; digit_sel = 4'b0111; load = 1'b1; value = 16'h1234;
    sel_show(4'b0111, "d3_pre");
    chk("d3_pre_seg", 16'(seg), 16'(S_0));
    sel_show(4'b1110, "d0_1234");
    chk("d0_1234_seg", 16'(seg), 16'(S_4));
    sel_show(4'b0111, "d3_1234");
    chk("d3_1234_seg", 16'(seg), 16'(S_1));

    // Bypass load on the frame-start edge.
    load = 1'b1; value = 16'h00AF;
    sel_show(4'b1110, "d0_af");
    chk("d0_af_seg", 16'(seg), 16'(S_F));
    sel_show(4'b1011, "d2_af");
    chk("d2_af_seg", 16'(seg), 16'(S_0));
    load = 1'b1; value = 16'hC0DE;
    tick();
    load = 1'b0;
    chk("d2_hold_an", 16'(an), 16'hB);
    chk("d2_hold_seg", 16'(seg), 16'(S_0));
    sel_show(4'b1101, "d1_af");
    chk("d1_af_seg", 16'(seg), 16'(S_A));
    sel_show(4'b1110, "d0_code");
    chk("d0_code_seg", 16'(seg), 16'(S_E));
    sel_show(4'b0111, "d3_code");
    chk("d3_code_seg", 16'(seg), 16'(S_C));

    // Leading-zero suppression and decimal point.
    load = 1'b1; value = 16'h0050; dp = 4'b0010; lz_suppress = 1'b1;
    sel_show(4'b1110, "d0_lz");
    chk("d0_lz_seg", 16'(seg), 16'(S_0));
    chk("d0_lz_dp", 16'(dp_n), 16'h1);
    sel_show(4'b1101, "d1_lz");
    chk("d1_lz_seg", 16'(seg), 16'(S_5));
    chk("d1_lz_dp", 16'(dp_n), 16'h0);
    sel_show(4'b1011, "d2_lz");
    chk("d2_lz_seg", 16'(seg), 16'(S_OFF));
    chk("d2_lz_dp", 16'(dp_n), 16'h1);
    sel_show(4'b0111, "d3_lz");
    chk("d3_lz_seg", 16'(seg), 16'(S_OFF));
    lz_suppress = 1'b0;
    tick();
    chk("d3_nolz_an", 16'(an), 16'h7);
    chk("d3_nolz_seg", 16'(seg), 16'(S_0));

    // Illegal select, then recovery with the sticky flag.
    digit_sel = 4'b1100;
    tick();
    chk("ill_err", 16'(sel_err), 16'h1);
    chk("ill_an", 16'(an), 16'hF);
    chk("ill_seg", 16'(seg), 16'(S_OFF));
    chk("ill_dpn", 16'(dp_n), 16'h1);
    tick();
    chk("ill_hold_an", 16'(an), 16'hF);
    sel_show(4'b1011, "d2_rec");
    chk("d2_rec_seg", 16'(seg), 16'(S_0));
    chk("d2_rec_err", 16'(sel_err), 16'h1);
    tick(); tick(); tick();
    chk("static_an", 16'(an), 16'hB);
    chk("static_err", 16'(sel_err), 16'h1);

    // Asynchronous reset mid-SHOW.
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_an", 16'(an), 16'hF);
    chk("mid_rst_seg", 16'(seg), 16'(S_OFF));
    chk("mid_rst_dpn", 16'(dp_n), 16'h1);
    chk("mid_rst_err", 16'(sel_err), 16'h0);
    tick();
    digit_sel = 4'b1110; reset = 1'b1;
    sel_show(4'b1110, "d0_after_rst");
    chk("d0_after_rst_seg", 16'(seg), 16'(S_0));
    chk("d0_after_rst_err", 16'(sel_err), 16'h0);
    sel_show(4'b1101, "d1_after_rst");
    chk("d1_after_rst_seg", 16'(seg), 16'(S_0));
    chk("d1_after_rst_dp", 16'(dp_n), 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
